// File: rtl/permute_seq_ctrl.sv
// Sequencing controller for the permutation datapath: per line it loads the state
// register, iterates ROUNDS round requests with a done handshake, then writes with back-pressure.
module permute_seq_ctrl #(
    parameter int LINES  = 64,
    parameter int IDX_W  = 6,
    parameter int ROUNDS = 24,
    parameter int RND_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cal_done,
    input  logic             wr_ready,
    output logic             dp_clr,
    output logic             read_file,
    output logic             write_reg,
    output logic             cal_start,
    output logic [RND_W-1:0] round_idx,
    output logic [IDX_W-1:0] line_index,
    output logic             write_file,
    output logic             busy,
    output logic             finish
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_READ  = 3'd2,
        S_LOAD  = 3'd3,
        S_CAL   = 3'd4,
        S_WAIT  = 3'd5,
        S_WRITE = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // Terminal counts are compared explicitly so LINES == 2**IDX_W never needs a wrap.
    localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(LINES - 1);
    localparam logic [RND_W-1:0] LAST_RND  = RND_W'(ROUNDS - 1);

    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] line_cnt_r;
    logic [IDX_W-1:0] line_cnt_s;
    logic [RND_W-1:0] rnd_cnt_r;
    logic [RND_W-1:0] rnd_cnt_s;
    logic [6:0]       out_r;

    // Strobe bits {dp_clr, read_file, write_reg, cal_start, write_file, busy, finish} for a state.
    function automatic logic [6:0] decode(input state_t s);
        logic [6:0] o;
        case (s)
            S_IDLE:  o = 7'b000_0000;
            S_INIT:  o = 7'b110_0010;
            S_READ:  o = 7'b000_0010;
            S_LOAD:  o = 7'b001_0010;
            S_CAL:   o = 7'b000_1010;
            S_WAIT:  o = 7'b000_0010;
            S_WRITE: o = 7'b000_0110;
            S_DONE:  o = 7'b000_0011;
            default: o = 7'b000_0000;
        endcase
        return o;
    endfunction

    // Next-state and counter update; abort overrides every other transition.
    always_comb begin
        state_s    = state_r;
        line_cnt_s = line_cnt_r;
        rnd_cnt_s  = rnd_cnt_r;
        if (abort && (state_r != S_IDLE)) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_s = S_INIT;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_INIT: begin
                    line_cnt_s = {IDX_W{1'b0}};
                    rnd_cnt_s  = {RND_W{1'b0}};
                    state_s    = S_READ;
                end
                S_READ: state_s = S_LOAD;
                S_LOAD: begin
                    rnd_cnt_s = {RND_W{1'b0}};
                    state_s   = S_CAL;
                end
                S_CAL:  state_s = S_WAIT;
                S_WAIT: begin
                    if (!cal_done) begin
                        state_s = S_WAIT;
                    end else if (rnd_cnt_r == LAST_RND) begin
                        state_s = S_WRITE;
                    end else begin
                        rnd_cnt_s = rnd_cnt_r + {{(RND_W-1){1'b0}}, 1'b1};
                        state_s   = S_CAL;
                    end
                end
                S_WRITE: begin
                    if (!wr_ready) begin
                        state_s = S_WRITE;
                    end else if (line_cnt_r == LAST_LINE) begin
                        state_s = S_DONE;
                    end else begin
                        line_cnt_s = line_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        state_s    = S_LOAD;
                    end
                end
                S_DONE:  state_s = S_IDLE;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // State, counters and strobe register; strobes are loaded from the next state so they stay Moore.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            line_cnt_r <= {IDX_W{1'b0}};
            rnd_cnt_r  <= {RND_W{1'b0}};
            out_r      <= 7'b000_0000;
        end else begin
            state_r    <= state_s;
            line_cnt_r <= line_cnt_s;
            rnd_cnt_r  <= rnd_cnt_s;
            out_r      <= decode(state_s);
        end
    end

    assign {dp_clr, read_file, write_reg, cal_start, write_file, busy, finish} = out_r;
    assign line_index = line_cnt_r;
    assign round_idx  = rnd_cnt_r;

endmodule

// File: tb/tb_permute_seq_ctrl.sv
// Directed bench for permute_seq_ctrl: four instances cover the minimal, default,
// back-pressure and full-index-range configurations.
module tb_permute_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start [4];
    logic       abort [4];
    logic       cal_done [4];
    logic       wr_ready [4];
    logic       dp_clr [4];
    logic       read_file [4];
    logic       write_reg [4];
    logic       cal_start [4];
    logic       write_file [4];
    logic       busy [4];
    logic       finish [4];
    logic [4:0] round_idx [3];
    logic [5:0] line_index [3];
    logic [0:0] round_idx_f;
    logic [1:0] line_index_f;

    int errors = 0;
    int checks = 0;

    permute_seq_ctrl #(.LINES(1), .IDX_W(6), .ROUNDS(1), .RND_W(5)) u_min (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .cal_done(cal_done[0]),
        .wr_ready(wr_ready[0]), .dp_clr(dp_clr[0]), .read_file(read_file[0]),
        .write_reg(write_reg[0]), .cal_start(cal_start[0]), .round_idx(round_idx[0]),
        .line_index(line_index[0]), .write_file(write_file[0]), .busy(busy[0]), .finish(finish[0]));

    permute_seq_ctrl #(.LINES(64), .IDX_W(6), .ROUNDS(24), .RND_W(5)) u_def (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .cal_done(cal_done[1]),
        .wr_ready(wr_ready[1]), .dp_clr(dp_clr[1]), .read_file(read_file[1]),
        .write_reg(write_reg[1]), .cal_start(cal_start[1]), .round_idx(round_idx[1]),
        .line_index(line_index[1]), .write_file(write_file[1]), .busy(busy[1]), .finish(finish[1]));

    permute_seq_ctrl #(.LINES(2), .IDX_W(6), .ROUNDS(2), .RND_W(5)) u_bp (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .cal_done(cal_done[2]),
        .wr_ready(wr_ready[2]), .dp_clr(dp_clr[2]), .read_file(read_file[2]),
        .write_reg(write_reg[2]), .cal_start(cal_start[2]), .round_idx(round_idx[2]),
        .line_index(line_index[2]), .write_file(write_file[2]), .busy(busy[2]), .finish(finish[2]));

    permute_seq_ctrl #(.LINES(4), .IDX_W(2), .ROUNDS(2), .RND_W(1)) u_full (
        .clk(clk), .rst(rst), .start(start[3]), .abort(abort[3]), .cal_done(cal_done[3]),
        .wr_ready(wr_ready[3]), .dp_clr(dp_clr[3]), .read_file(read_file[3]),
        .write_reg(write_reg[3]), .cal_start(cal_start[3]), .round_idx(round_idx_f),
        .line_index(line_index_f), .write_file(write_file[3]), .busy(busy[3]), .finish(finish[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed strobes {dp_clr, read_file, write_reg, cal_start, write_file, busy, finish}.
    function automatic logic [6:0] outs(input int k);
        return {dp_clr[k], read_file[k], write_reg[k], cal_start[k], write_file[k], busy[k], finish[k]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (outs(k) !== 7'b000_0000) begin
                    errors++;
                    $display("FAIL reset_idle inst%0d cyc%0d: got %b expected 0000000", k, c, outs(k));
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (line_index[k] !== 6'd0 || round_idx[k] !== 5'd0) begin
                errors++;
                $display("FAIL reset_counters inst%0d: got %0d/%0d expected 0/0", k, line_index[k], round_idx[k]);
            end
        end
    endtask

    task automatic test_minimal;
        logic [6:0] e;
        cal_done[0] = 1'b1;
        wr_ready[0] = 1'b1;
        start[0]    = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick;
            start[0] = 1'b0;
            case (c)
                1:       e = 7'b110_0010;
                2:       e = 7'b000_0010;
                3:       e = 7'b001_0010;
                4:       e = 7'b000_1010;
                5:       e = 7'b000_0010;
                6:       e = 7'b000_0110;
                7:       e = 7'b000_0011;
                default: e = 7'b000_0000;
            endcase
            checks++;
            if (outs(0) !== e) begin
                errors++;
                $display("FAIL minimal cyc%0d: got %b expected %b", c, outs(0), e);
            end
        end
    endtask

    task automatic run_check(input int k, input int lines, input int rounds,
                             input int exp_len, input bit poke, input string name);
        int nwr, nhs, rexp, fin_c;
        nwr = 0; nhs = 0; rexp = 0; fin_c = 0;
        cal_done[k] = 1'b1;
        wr_ready[k] = 1'b1;
        start[k]    = 1'b1;
        for (int c = 1; c <= exp_len + 10 && fin_c == 0; c++) begin
            tick;
            start[k] = poke && (c >= 3) && (c <= 6);
            if (write_reg[k]) begin
                checks++;
                if (line_index[k] !== 6'(nwr)) begin
                    errors++;
                    $display("FAIL %s line_index: got %0d expected %0d", name, line_index[k], nwr);
                end
                nwr++;
                rexp = 0;
            end
            if (cal_start[k]) begin
                checks++;
                if (round_idx[k] !== 5'(rexp)) begin
                    errors++;
                    $display("FAIL %s round_idx line%0d: got %0d expected %0d", name, nwr - 1, round_idx[k], rexp);
                end
                rexp++;
            end
            if (write_file[k]) begin
                checks++;
                if (rexp !== rounds) begin
                    errors++;
                    $display("FAIL %s rounds_per_line: got %0d expected %0d", name, rexp, rounds);
                end
                nhs++;
            end
            if (finish[k]) fin_c = c;
        end
        start[k] = 1'b0;
        checks++;
        if (nwr !== lines) begin
            errors++;
            $display("FAIL %s write_reg_count: got %0d expected %0d", name, nwr, lines);
        end
        checks++;
        if (nhs !== lines) begin
            errors++;
            $display("FAIL %s handshakes: got %0d expected %0d", name, nhs, lines);
        end
        checks++;
        if (fin_c !== exp_len) begin
            errors++;
            $display("FAIL %s finish_cycle: got %0d expected %0d", name, fin_c, exp_len);
        end
        tick;
        tick;
        checks++;
        if (outs(k) !== 7'b000_0000) begin
            errors++;
            $display("FAIL %s idle_after: got %b expected 0000000", name, outs(k));
        end
    endtask

    task automatic test_backpressure;
        logic [6:0] e;
        cal_done[2] = 1'b1;
        wr_ready[2] = 1'b1;
        start[2]    = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick;
            start[2]    = 1'b0;
            cal_done[2] = !((c >= 7) && (c <= 9));
            wr_ready[2] = !((c >= 11) && (c <= 13));
            case (c)
                1:                   e = 7'b110_0010;
                3, 15:               e = 7'b001_0010;
                4, 6, 16, 18:        e = 7'b000_1010;
                2, 5, 7, 8, 9, 10, 17, 19: e = 7'b000_0010;
                11, 12, 13, 14, 20:  e = 7'b000_0110;
                21:                  e = 7'b000_0011;
                default:             e = 7'b000_0000;
            endcase
            checks++;
            if (outs(2) !== e) begin
                errors++;
                $display("FAIL backpressure cyc%0d: got %b expected %b", c, outs(2), e);
            end
            if (c >= 7 && c <= 10) begin
                checks++;
                if (round_idx[2] !== 5'd1) begin
                    errors++;
                    $display("FAIL bp_round_hold cyc%0d: got %0d expected 1", c, round_idx[2]);
                end
            end
            if (c >= 11 && c <= 14) begin
                checks++;
                if (line_index[2] !== 6'd0) begin
                    errors++;
                    $display("FAIL bp_line_hold cyc%0d: got %0d expected 0", c, line_index[2]);
                end
            end
        end
        checks++;
        if (line_index[2] !== 6'd1 || round_idx[2] !== 5'd1) begin
            errors++;
            $display("FAIL bp_final_counters: got %0d/%0d expected 1/1", line_index[2], round_idx[2]);
        end
    endtask

    task automatic test_abort;
        bit found;
        bit bad;
        found = 1'b0;
        bad   = 1'b0;
        cal_done[1] = 1'b1;
        wr_ready[1] = 1'b1;
        start[1]    = 1'b1;
        for (int c = 0; c < 2000 && !found; c++) begin
            tick;
            start[1] = 1'b0;
            if (write_reg[1] && line_index[1] == 6'd5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_line5: got 0 expected 1");
        end
        cal_done[1] = 1'b0;
        tick;
        tick;
        checks++;
        if (outs(1) !== 7'b000_0010) begin
            errors++;
            $display("FAIL abort_in_wait: got %b expected 0000010", outs(1));
        end
        abort[1] = 1'b1;
        tick;
        abort[1]    = 1'b0;
        cal_done[1] = 1'b1;
        checks++;
        if (outs(1) !== 7'b000_0000) begin
            errors++;
            $display("FAIL abort_idle: got %b expected 0000000", outs(1));
        end
        checks++;
        if (line_index[1] !== 6'd5 || round_idx[1] !== 5'd0) begin
            errors++;
            $display("FAIL abort_counters_hold: got %0d/%0d expected 5/0", line_index[1], round_idx[1]);
        end
        for (int c = 0; c < 20; c++) begin
            tick;
            if (outs(1) !== 7'b000_0000) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_stays_idle: got activity expected none");
        end
        start[1] = 1'b1;
        tick;
        start[1] = 1'b0;
        tick;
        tick;
        checks++;
        if (outs(1) !== 7'b001_0010 || line_index[1] !== 6'd0) begin
            errors++;
            $display("FAIL abort_restart: got %b line %0d expected 0010010 line 0", outs(1), line_index[1]);
        end
        abort[1] = 1'b1;
        tick;
        abort[1] = 1'b0;
        checks++;
        if (outs(1) !== 7'b000_0000) begin
            errors++;
            $display("FAIL abort_second: got %b expected 0000000", outs(1));
        end
    endtask

    task automatic test_mid_rst;
        bit found;
        bit bad;
        found = 1'b0;
        bad   = 1'b0;
        run_check(2, 2, 2, 15, 1'b1, "ignored_start");
        cal_done[2] = 1'b1;
        wr_ready[2] = 1'b1;
        start[2]    = 1'b1;
        for (int c = 0; c < 40 && !found; c++) begin
            tick;
            start[2] = 1'b0;
            if (write_file[2] && line_index[2] == 6'd1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_reach_write: got 0 expected 1");
        end
        rst      = 1'b1;
        abort[2] = 1'b1;
        tick;
        rst      = 1'b0;
        abort[2] = 1'b0;
        checks++;
        if (outs(2) !== 7'b000_0000) begin
            errors++;
            $display("FAIL rst_outputs: got %b expected 0000000", outs(2));
        end
        checks++;
        if (line_index[2] !== 6'd0 || round_idx[2] !== 5'd0) begin
            errors++;
            $display("FAIL rst_counters: got %0d/%0d expected 0/0", line_index[2], round_idx[2]);
        end
        for (int c = 0; c < 10; c++) begin
            tick;
            if (outs(2) !== 7'b000_0000) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_no_finish: got activity expected none");
        end
    endtask

    task automatic test_full_range;
        int nwr, rexp, fin_c;
        nwr = 0; rexp = 0; fin_c = 0;
        cal_done[3] = 1'b1;
        wr_ready[3] = 1'b1;
        start[3]    = 1'b1;
        for (int c = 1; c <= 40 && fin_c == 0; c++) begin
            tick;
            start[3] = 1'b0;
            if (write_reg[3]) begin
                checks++;
                if (line_index_f !== 2'(nwr)) begin
                    errors++;
                    $display("FAIL full_line_index: got %0d expected %0d", line_index_f, nwr);
                end
                nwr++;
                rexp = 0;
            end
            if (cal_start[3]) begin
                checks++;
                if (round_idx_f !== 1'(rexp)) begin
                    errors++;
                    $display("FAIL full_round_idx: got %0d expected %0d", round_idx_f, rexp);
                end
                rexp++;
            end
            if (finish[3]) fin_c = c;
        end
        checks++;
        if (nwr !== 4) begin
            errors++;
            $display("FAIL full_lines: got %0d expected 4", nwr);
        end
        checks++;
        if (fin_c !== 27) begin
            errors++;
            $display("FAIL full_finish_cycle: got %0d expected 27", fin_c);
        end
        tick;
        checks++;
        if (outs(3) !== 7'b000_0000) begin
            errors++;
            $display("FAIL full_idle_after: got %b expected 0000000", outs(3));
        end
    endtask

    // Stimulus sequencing and final summary of failed versus total comparisons.
    initial begin
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            start[k]    = 1'b0;
            abort[k]    = 1'b0;
            cal_done[k] = 1'b0;
            wr_ready[k] = 1'b0;
        end
        test_reset;
        test_minimal;
        run_check(1, 64, 24, 3203, 1'b0, "defaults");
        test_backpressure;
        test_abort;
        test_mid_rst;
        test_full_range;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
